// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the IF stage front end and its neighbours.
//   - fetch_state_e     : fetch FSM encoding (FETCH / HOLD)
//   - RESET_PC_DEFAULT  : default PC loaded on reset
//   - BUBBLE_DEFAULT    : instruction word presented when nothing is valid
//   - OPC_* / FUNCT_JR  : j/jr/branch encodings used by the IF/ID flush logic
//   - align_word()      : clears the two low address bits
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    typedef enum logic {
        FETCH = 1'b0,   // request outstanding (or about to be issued)
        HOLD  = 1'b1    // fetched word captured and presented
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_DEFAULT   = 32'hFFFF_FFFF;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_redirect_mux.sv
// ---------------------------------------------------------------------------
// if_redirect_mux
// Combinational redirect select shared by the fetch unit and hazard unit.
// Branch resolution wins over a jump when both fire; the chosen target is
// forced onto a word boundary.
// Ports:
//   branch_taken_i / branch_target_i : branch redirect request and target
//   jump_taken_i   / jump_target_i   : j/jr redirect request and target
//   redirect_o                       : any redirect requested this cycle
//   target_o                         : selected, word-aligned target
// ---------------------------------------------------------------------------
module if_redirect_mux
    import if_fetch_unit_pkg::*;
(
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_taken_i,
    input  logic [31:0] jump_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    always_comb begin
        redirect_o = branch_taken_i | jump_taken_i;
        target_o   = align_word(branch_taken_i ? branch_target_i : jump_target_i);
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// IF-stage front end: owns the PC, runs a req/ack handshake to instruction
// memory and feeds PC/instruction into the IF/ID register. One fetch is in
// flight at a time (no prefetch).
//
// Handshake: imem_req stays high with imem_addr stable until a one-cycle
// imem_ack arrives; imem_rdata is valid in the ack cycle. A request is never
// withdrawn except by reset.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   pc_write            : 1 = advance, 0 = stall the presented instruction
//   branch_taken/target : branch redirect
//   jump_taken/target   : j/jr redirect (lower priority than branch)
//   imem_req/addr       : fetch request and word-aligned address
//   imem_ack/rdata      : fetch completion and data
//   PC                  : PC+4 of the presented instruction
//   instruction         : presented word, or BUBBLE
//   fetch_valid         : instruction holds a real fetched word
//   dbg_state           : current fetch FSM state
// Optional (IF_FETCH_PERF_EN):
//   stall_cycles        : saturating count of HOLD cycles with pc_write=0
//   discarded_fetches   : saturating count of acks dropped while discarding
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] BUBBLE   = BUBBLE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_write,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         jump_taken,
    input  logic [31:0]  jump_target,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  PC,
    output logic [31:0]  instruction,
    output logic         fetch_valid,
    output fetch_state_e dbg_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  discarded_fetches
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;          // architectural fetch PC
    logic [31:0]  addr_q, addr_d;      // address of the in-flight request
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;
    logic         discard_q, discard_d;
    logic         armed_q;             // low only until the first edge after reset

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         ack_seen;

    if_redirect_mux u_redirect_mux (
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_taken_i    (jump_taken),
        .jump_target_i   (jump_target),
        .redirect_o      (redirect),
        .target_o        (redirect_target)
    );

    // An ack only counts while a request is actually on the bus.
    assign ack_seen = armed_q && (state_q == FETCH) && imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            instr_q   <= BUBBLE;
            pc_out_q  <= RESET_PC + 32'd4;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            valid_q   <= valid_d;
            discard_q <= discard_d;
            armed_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;
        discard_d = discard_q;

        unique case (state_q)
            FETCH: begin
                if (ack_seen) begin
                    if (discard_q || redirect) begin
                        // Stale or superseded word: drop it and reissue at
                        // the newest PC.
                        pc_d      = redirect ? redirect_target : pc_q;
                        addr_d    = pc_d;
                        discard_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q + 32'd4;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (redirect) begin
                    pc_d = redirect_target;
                    if (armed_q) begin
                        // Request in flight keeps its address; its data is
                        // thrown away when the ack finally arrives.
                        discard_d = 1'b1;
                    end else begin
                        addr_d = redirect_target;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    addr_d  = redirect_target;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (pc_write) begin
                    pc_d    = pc_q + 32'd4;
                    addr_d  = pc_q + 32'd4;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req    = armed_q && (state_q == FETCH);
    assign imem_addr   = addr_q;
    assign PC          = pc_out_q;
    assign instruction = instr_q;
    assign fetch_valid = valid_q;
    assign dbg_state   = state_q;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_q, disc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            disc_q  <= '0;
        end else begin
            if ((state_q == HOLD) && !pc_write && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ack_seen && discard_q && (disc_q != 32'hFFFF_FFFF)) begin
                disc_q <= disc_q + 32'd1;
            end
        end
    end

    assign stall_cycles      = stall_q;
    assign discarded_fetches = disc_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit. A memory model answers requests after a random
// delay. The reference model tracks only the program-order fetch address:
// reset starts at 0, a redirect replaces the next expected address with the
// aligned target (branch before jump), an advance from a presented
// instruction adds 4. Each expected address is queued; the monitor pops one
// whenever a new valid instruction appears and checks word, PC and address.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BUB    = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         pc_write = 1'b0;
    logic         branch_taken = 1'b0;
    logic [31:0]  branch_target = '0;
    logic         jump_taken = 1'b0;
    logic [31:0]  jump_target = '0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic [31:0]  PC;
    logic [31:0]  instruction;
    logic         fetch_valid;
    fetch_state_e dbg_state;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]  stall_cycles;
    logic [31:0]  discarded_fetches;
`endif

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_taken    (jump_taken),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .PC            (PC),
        .instruction   (instruction),
        .fetch_valid   (fetch_valid),
        .dbg_state     (dbg_state)
`ifdef IF_FETCH_PERF_EN
        ,
        .stall_cycles      (stall_cycles),
        .discarded_fetches (discarded_fetches)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] last_addr;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents; address 0 holds 32'h2002_0005.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2002_0005;
    endfunction

    function automatic void model_redirect(input logic [31:0] t);
        exp_pc = t & 32'hFFFF_FFFC;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        exp_q.push_back(exp_pc);
    endfunction

    // ---------------- memory model ----------------
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        mem_busy   = 1'b0;
        mem_addr   = '0;
        mem_cnt    = 0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (rst) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy && imem_req) begin
                    mem_busy = 1'b1;
                    mem_addr = imem_addr;
                    mem_cnt  = $urandom_range(0, 3);
                    check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
                end
                if (mem_busy) begin
                    check("req_held", {31'd0, imem_req}, 32'd1);
                    check("addr_stable", imem_addr, mem_addr);
                    if (mem_cnt == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem_word(mem_addr);
                        mem_busy   = 1'b0;
                    end else begin
                        mem_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    int   idle_cnt = 0;
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
                idle_cnt   = 0;
            end else begin
                if (fetch_valid && !prev_valid) begin
                    idle_cnt = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_delivery", imem_addr, BUB);
                    end else begin
                        e = exp_q.pop_front();
                        last_addr = e;
                        check("deliver_instr", instruction, mem_word(e));
                        check("deliver_pc", PC, e + 32'd4);
                        check("deliver_addr", imem_addr, e);
                    end
                end else if (exp_q.size() != 0) begin
                    idle_cnt++;
                    if (idle_cnt > 100) begin
                        check("delivery_timeout", {31'd0, fetch_valid}, 32'd1);
                        idle_cnt = 0;
                    end
                end
                if (!fetch_valid) check("bubble_when_invalid", instruction, BUB);
                prev_valid = fetch_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic pw, input logic be, input logic [31:0] bt,
                        input logic je, input logic [31:0] jt);
        @(negedge clk);
        pc_write      = pw;
        branch_taken  = be;
        branch_target = bt;
        jump_taken    = je;
        jump_target   = jt;
        if (be)                    model_redirect(bt);
        else if (je)               model_redirect(jt);
        else if (pw && fetch_valid) begin
            exp_pc = exp_pc + 32'd4;
            exp_q.push_back(exp_pc);
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (fetch_valid) ok = 1'b1;
        end
        if (!ok) check("wait_valid_timeout", {31'd0, fetch_valid}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] stall0;
        bit          found;
        stall0 = '0;
        exp_pc = RST_PC;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_instr", instruction, BUB);
        check("rst_pc", PC, RST_PC + 32'd4);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        exp_q.push_back(RST_PC);
        rst = 1'b0;
        #1 check("req_low_before_edge", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("req_after_release", {31'd0, imem_req}, 32'd1);
        check("addr_after_release", imem_addr, RST_PC);
        wait_valid();

        // Advance to 4, then stall for five cycles
        step(1'b1, 1'b0, '0, 1'b0, '0);
        wait_valid();
`ifdef IF_FETCH_PERF_EN
        stall0 = stall_cycles;
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0);
            @(posedge clk);
            #1;
            check("stall_instr", instruction, mem_word(last_addr));
            check("stall_pc", PC, last_addr + 32'd4);
            check("stall_valid", {31'd0, fetch_valid}, 32'd1);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_state", {31'd0, dbg_state}, {31'd0, HOLD});
        end
`ifdef IF_FETCH_PERF_EN
        check("stall_cycles", stall_cycles - stall0, 32'd5);
`else
        check("stall_last_addr", last_addr, 32'd4);
`endif

        // Jump while stalled to an unaligned target
        step(1'b0, 1'b0, '0, 1'b1, 32'h0000_1003);
        wait_valid();
        check("jump_stall_pc", PC, 32'h0000_1004);

        // Branch and jump together during an outstanding fetch: branch wins
        step(1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        wait_valid();
        check("priority_addr", last_addr, 32'h0000_0100);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, '0);
        wait_valid();
        step(1'b1, 1'b0, '0, 1'b0, '0);
        wait_valid();
        check("wrap_addr", last_addr, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            step($urandom_range(0, 3) != 0, (r == 0) || (r == 2), $urandom,
                 (r == 1) || (r == 2), $urandom);
        end

        // Reset while a request is outstanding
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, '0);
            @(posedge clk);
            #1;
            if (imem_req && !fetch_valid) found = 1'b1;
        end
        check("found_outstanding", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_instr", instruction, BUB);
        check("midrst_valid", {31'd0, fetch_valid}, 32'd0);
        check("midrst_addr", imem_addr, RST_PC);
        exp_q.delete();
        exp_pc = RST_PC;
        exp_q.push_back(RST_PC);
        repeat (2) @(negedge clk);
        pc_write = 1'b0;
        branch_taken = 1'b0;
        jump_taken = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, RST_PC);
        wait_valid();
        check("restart_deliver", last_addr, RST_PC);

        // Drain any outstanding expectation
        step(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
